// File: rtl/ct_had_pcfifo_pkg.sv
// Shared constants and FSM encoding for the HAD PC trace FIFO.
// The FIFO and its drain sequencer both use these definitions.
package ct_had_pcfifo_pkg;

  localparam int DATAW     = 64;
  localparam int DEPTH     = 16;
  localparam int CNT_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_CAPT = 2'd2,
    ST_SEND = 2'd3
  } drain_st_e;

endpackage

// File: rtl/ct_had_drain_cnt.sv
// Burst length clamp and remaining-entry counter for the PC FIFO drain.
// A zero or oversized request becomes a full-depth burst.
module ct_had_drain_cnt #(
  parameter int DEPTH     = ct_had_pcfifo_pkg::DEPTH,
  parameter int CNT_WIDTH = ct_had_pcfifo_pkg::CNT_WIDTH
) (
  input  logic                 cpuclk,
  input  logic                 cpurst_b,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_cnt,
  input  logic                 i_dec,
  output logic [CNT_WIDTH-1:0] o_rem,
  output logic                 o_last,
  output logic                 o_zero
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

  logic [CNT_WIDTH-1:0] w_clamp;
  logic [CNT_WIDTH-1:0] r_rem;

  // Map 0 and anything above the FIFO depth onto a full-depth burst
  always_comb begin
    w_clamp = i_cnt;
    if (i_cnt == '0 || i_cnt > DEPTH_C)
      w_clamp = DEPTH_C;
  end

  // Remaining entries: loaded on an accepted request, stepped per counted beat
  always_ff @(posedge cpuclk) begin
    if (!cpurst_b)
      r_rem <= '0;
    else if (i_load)
      r_rem <= w_clamp;
    else if (i_dec)
      r_rem <= r_rem - 1'b1;
  end

  assign o_rem  = r_rem;
  assign o_last = (r_rem == CNT_WIDTH'(1));
  assign o_zero = (r_rem == '0);

endmodule

// File: rtl/ct_had_pcfifo_drain.sv
// Read-side sequencer: strobes the PC FIFO and streams entries to HAD.
// Optional checksum is enabled by defining HAD_PCFIFO_DRAIN_CSUM_EN.
module ct_had_pcfifo_drain #(
  parameter int DATAW     = 64,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 cpuclk,
  input  logic                 cpurst_b,
  input  logic                 regs_drain_req,
  input  logic [CNT_WIDTH-1:0] regs_drain_cnt,
  input  logic                 regs_drain_abort,
  input  logic [DATAW-1:0]     pcfifo_regs_data,
  output logic                 ctrl_pcfifo_ren,
  output logic [DATAW-1:0]     drain_data,
  output logic                 drain_vld,
  input  logic                 drain_rdy,
  output logic                 drain_last,
  output logic                 drain_busy,
  output logic                 drain_done,
  output logic                 drain_aborted,
  output logic [DATAW-1:0]     drain_csum
);

  import ct_had_pcfifo_pkg::*;

  drain_st_e            r_state;
  drain_st_e            w_next;
  logic                 w_req_ok;
  logic                 w_abort;
  logic                 w_hs;
  logic                 w_fin;
  logic                 w_last;
  logic                 w_zero;
  logic [CNT_WIDTH-1:0] w_rem;
  logic [DATAW-1:0]     r_data;
  logic                 r_done;
  logic                 r_aborted;

  // Abort has priority over both a new request and a beat handshake
  assign w_req_ok = (r_state == ST_IDLE) && regs_drain_req
                    && !regs_drain_abort;
  assign w_abort  = (r_state != ST_IDLE) && regs_drain_abort;
  assign w_hs     = (r_state == ST_SEND) && drain_rdy
                    && !regs_drain_abort;
  assign w_fin    = w_hs && w_last;

  ct_had_drain_cnt #(
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt (
    .cpuclk   (cpuclk),
    .cpurst_b (cpurst_b),
    .i_load   (w_req_ok),
    .i_cnt    (regs_drain_cnt),
    .i_dec    (w_hs && !w_zero),
    .o_rem    (w_rem),
    .o_last   (w_last),
    .o_zero   (w_zero)
  );

  // State register
  always_ff @(posedge cpuclk) begin
    if (!cpurst_b)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  // Next state: one strobe, one capture, then hold the beat until taken
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_req_ok) w_next = ST_READ;
      ST_READ: w_next = ST_CAPT;
      ST_CAPT: w_next = ST_SEND;
      ST_SEND: if (w_hs) w_next = w_last ? ST_IDLE : ST_READ;
      default: w_next = ST_IDLE;
    endcase
    if (w_abort)
      w_next = ST_IDLE;
  end

  // State-decoded outputs
  always_comb begin
    ctrl_pcfifo_ren = (r_state == ST_READ);
    drain_vld       = (r_state == ST_SEND);
    drain_busy      = (r_state != ST_IDLE);
  end

  // Beat capture and completion status
  always_ff @(posedge cpuclk) begin
    if (!cpurst_b) begin
      r_data    <= '0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      if (r_state == ST_CAPT)
        r_data <= pcfifo_regs_data;
      r_done <= w_abort || w_fin;
      if (w_req_ok)
        r_aborted <= 1'b0;
      else if (w_abort)
        r_aborted <= 1'b1;
    end
  end

  assign drain_data    = r_data;
  assign drain_done    = r_done;
  assign drain_aborted = r_aborted;
  assign drain_last    = drain_vld && w_last;

`ifdef HAD_PCFIFO_DRAIN_CSUM_EN
  logic [DATAW-1:0] r_csum;

  // XOR of every counted beat since the last accepted request
  always_ff @(posedge cpuclk) begin
    if (!cpurst_b)
      r_csum <= '0;
    else if (w_req_ok)
      r_csum <= '0;
    else if (w_hs)
      r_csum <= r_csum ^ r_data;
  end

  assign drain_csum = r_csum;
`else
  assign drain_csum = '0;
`endif

endmodule
